// File: rtl/qspi_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : qspi_fill_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one QSPI flash burst
//            reader between an instruction-side and a data-side line-fill
//            requester. Grants for a whole burst, issues start + address,
//            steers returned words to the owner and signals completion.
// Options  : define FILL_ARB_TIMEOUT_EN to build the stall timeout that
//            aborts a burst after TIMEOUT consecutive word-less XFER cycles.
// Revision : 1.0 - initial release
// ============================================================================
module qspi_fill_arbiter #(
  parameter int WORDS   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        r0_req,
  input  logic [23:0] r0_addr,
  input  logic        r1_req,
  input  logic [23:0] r1_addr,
  output logic        r0_valid,
  output logic [31:0] r0_rdata,
  output logic        r0_done,
  output logic        r0_err,
  output logic        r1_valid,
  output logic [31:0] r1_rdata,
  output logic        r1_done,
  output logic        r1_err,
  output logic        fr_start,
  output logic [23:0] fr_addr,
  output logic        fr_abort,
  input  logic        fr_wvalid,
  input  logic [31:0] fr_wdata,
  input  logic        fr_done
);

  localparam int c_cnt_w = $clog2(WORDS + 1);
  localparam logic [c_cnt_w-1:0] c_words = c_cnt_w'(WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;   // 0: r0 owns the reader, 1: r1
  logic                last_q, last_d;     // requester granted most recently
  logic [23:0]         fr_addr_q, fr_addr_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;       // words forwarded in this burst

  logic                r0_valid_q, r1_valid_q;
  logic [31:0]         r0_rdata_q, r1_rdata_q;
  logic                r0_done_q, r1_done_q;
  logic                fr_start_q;

  logic                w_pick1;   // arbitration result if a grant happens now
  logic                w_fwd;     // current strobe is delivered to the owner
  logic                w_end;     // burst ends at this edge
  logic                w_expire;  // stall timeout reached this cycle

  // Parameter sanity check at elaboration time.
  if (WORDS < 1 || TIMEOUT < 2) begin : g_param_check
    $error("qspi_fill_arbiter: WORDS must be >= 1 and TIMEOUT >= 2");
  end

  // r1 wins when it is alone, or on a tie when r0 was the last one served.
  assign w_pick1 = r1_req & (~r0_req | ~last_q);
  assign w_fwd   = (state_q == ST_XFER) & fr_wvalid & (cnt_q < c_words);
  assign w_end   = (state_q == ST_XFER) & (state_d == ST_DONE);

  // Next-state logic for the burst sequencer.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    fr_addr_d = fr_addr_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (r0_req | r1_req) begin
          state_d   = ST_START;
          owner_d   = w_pick1;
          last_d    = w_pick1;
          fr_addr_d = w_pick1 ? r1_addr : r0_addr;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_XFER;
      end
      ST_XFER: begin
        if (w_fwd) begin
          cnt_d = cnt_q + 1'b1;
        end
        // A coincident fr_done wins over expiry; both lead to DONE and the
        // abort flag below is qualified with ~fr_done.
        if (fr_done | w_expire) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, grant bookkeeping and latched burst address.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      fr_addr_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      fr_addr_q <= fr_addr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Registered requester-facing strobes, data and the reader start pulse.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r0_valid_q <= 1'b0;
      r1_valid_q <= 1'b0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
      r0_done_q  <= 1'b0;
      r1_done_q  <= 1'b0;
      fr_start_q <= 1'b0;
    end else begin
      r0_valid_q <= w_fwd & ~owner_q;
      r1_valid_q <= w_fwd & owner_q;
      if (w_fwd & ~owner_q) begin
        r0_rdata_q <= fr_wdata;
      end
      if (w_fwd & owner_q) begin
        r1_rdata_q <= fr_wdata;
      end
      r0_done_q  <= w_end & ~owner_q;
      r1_done_q  <= w_end & owner_q;
      fr_start_q <= (state_d == ST_START);
    end
  end

`ifdef FILL_ARB_TIMEOUT_EN
  localparam int c_to_w = $clog2(TIMEOUT + 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT - 1);

  logic [c_to_w-1:0] to_cnt_q, to_cnt_d;
  logic              r0_err_q, r1_err_q, fr_abort_q;
  logic              w_abort;

  // Expiry is the cycle that would make the idle run reach TIMEOUT.
  assign w_expire = (state_q == ST_XFER) & ~fr_wvalid & (to_cnt_q == c_to_last);
  assign w_abort  = w_expire & ~fr_done;

  // Count consecutive XFER cycles without a reader strobe.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == ST_START) begin
      to_cnt_d = '0;
    end else if (state_q == ST_XFER) begin
      to_cnt_d = fr_wvalid ? '0 : to_cnt_q + 1'b1;
    end
  end

  // Timeout counter and the abort/error pulses issued with DONE.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      to_cnt_q   <= '0;
      fr_abort_q <= 1'b0;
      r0_err_q   <= 1'b0;
      r1_err_q   <= 1'b0;
    end else begin
      to_cnt_q   <= to_cnt_d;
      fr_abort_q <= w_abort;
      r0_err_q   <= w_abort & ~owner_q;
      r1_err_q   <= w_abort & owner_q;
    end
  end

  assign fr_abort = fr_abort_q;
  assign r0_err   = r0_err_q;
  assign r1_err   = r1_err_q;
`else
  assign w_expire = 1'b0;
  assign fr_abort = 1'b0;
  assign r0_err   = 1'b0;
  assign r1_err   = 1'b0;
`endif

  assign r0_valid = r0_valid_q;
  assign r1_valid = r1_valid_q;
  assign r0_rdata = r0_rdata_q;
  assign r1_rdata = r1_rdata_q;
  assign r0_done  = r0_done_q;
  assign r1_done  = r1_done_q;
  assign fr_start = fr_start_q;
  assign fr_addr  = fr_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_qspi_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_qspi_fill_arbiter
// Brief    : Self-checking bench for qspi_fill_arbiter: a directed vector
//            table, hand sequences for arbitration timing, reset and timeout,
//            and a randomized burst run against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qspi_fill_arbiter;

  localparam int WORDS   = 4;
  localparam int TIMEOUT = 8;

  logic        HCLK, HRESET;
  logic        r0_req, r1_req;
  logic [23:0] r0_addr, r1_addr;
  logic        r0_valid, r1_valid, r0_done, r1_done, r0_err, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        fr_start, fr_abort;
  logic [23:0] fr_addr;
  logic        fr_wvalid, fr_done;
  logic [31:0] fr_wdata;

  int nvec = 0;
  int nmis = 0;

  qspi_fill_arbiter #(.WORDS(WORDS), .TIMEOUT(TIMEOUT)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .r0_req(r0_req), .r0_addr(r0_addr), .r1_req(r1_req), .r1_addr(r1_addr),
    .r0_valid(r0_valid), .r0_rdata(r0_rdata), .r0_done(r0_done), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_rdata(r1_rdata), .r1_done(r1_done), .r1_err(r1_err),
    .fr_start(fr_start), .fr_addr(fr_addr), .fr_abort(fr_abort),
    .fr_wvalid(fr_wvalid), .fr_wdata(fr_wdata), .fr_done(fr_done)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Control strobes packed as {v0,v1,done0,done1,err0,err1,start,abort}.
  function automatic logic [7:0] ctl();
    return {r0_valid, r1_valid, r0_done, r1_done, r0_err, r1_err, fr_start, fr_abort};
  endfunction

  function automatic logic [95:0] outs();
    return {ctl(), r0_rdata, r1_rdata, fr_addr};
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic clr_in();
    r0_req = 1'b0; r1_req = 1'b0; r0_addr = '0; r1_addr = '0;
    fr_wvalid = 1'b0; fr_wdata = '0; fr_done = 1'b0;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    clr_in();
    tick();
    tick();
    chk("reset state", outs(), 96'h0);
    HRESET = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r0q, r1q, wv, fd;
    logic [31:0] wd;
    logic [7:0]  ectl;
    logic [23:0] fa;
    logic [31:0] d;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic r0q, input logic r1q, input logic wv,
                              input logic [31:0] wd, input logic fd,
                              input logic [7:0] ectl, input logic [23:0] fa,
                              input logic [31:0] d);
    vec_t v;
    v.r0q = r0q; v.r1q = r1q; v.wv = wv; v.wd = wd; v.fd = fd;
    v.ectl = ectl; v.fa = fa; v.d = d;
    return v;
  endfunction

  // ---------------- randomized run model state ----------------
  bit          pend[2];
  logic [23:0] maddr[2];
  bit          mlast;
  bit          mown;
  int          mcnt;
  logic [23:0] mgaddr;

  // One XFER cycle: drive the reader, then compare against the model.
  task automatic xcyc(input logic wv, input logic [31:0] wd, input logic fd);
    logic [7:0] e;
    bit fwd;
    fr_wvalid = wv; fr_wdata = wd; fr_done = fd;
    if (mown) r1_addr = 24'($urandom); else r0_addr = 24'($urandom);
    tick();
    fwd = wv && (mcnt < WORDS);
    if (fwd) mcnt++;
    e = 8'h00;
    if (fwd) e = e | (mown ? 8'h40 : 8'h80);
    if (fd)  e = e | (mown ? 8'h10 : 8'h20);
    chk("rnd ctl", 96'(ctl()), 96'(e));
    chk("rnd fr_addr", 96'(fr_addr), 96'(mgaddr));
    if (fwd) chk("rnd rdata", 96'(mown ? r1_rdata : r0_rdata), 96'(wd));
  endtask

  initial begin
    logic [7:0] acc;
    HRESET = 1'b0;
    clr_in();
    do_reset();

    // ---- table: single r0 burst, then r1 burst with an excess strobe ----
    tbl[0]  = mk(1,0,0,32'h0 ,0, 8'h02, 24'h000010, 32'h0);
    tbl[1]  = mk(1,0,0,32'h0 ,0, 8'h00, 24'h000010, 32'h0);
    tbl[2]  = mk(1,0,1,32'hA0,0, 8'h80, 24'h000010, 32'hA0);
    tbl[3]  = mk(1,0,1,32'hA1,0, 8'h80, 24'h000010, 32'hA1);
    tbl[4]  = mk(1,0,1,32'hA2,0, 8'h80, 24'h000010, 32'hA2);
    tbl[5]  = mk(1,0,1,32'hA3,1, 8'hA0, 24'h000010, 32'hA3);
    tbl[6]  = mk(0,0,0,32'h0 ,0, 8'h00, 24'h000010, 32'h0);
    tbl[7]  = mk(0,0,0,32'h0 ,0, 8'h00, 24'h000010, 32'h0);
    tbl[8]  = mk(0,1,0,32'h0 ,0, 8'h02, 24'h000200, 32'h0);
    tbl[9]  = mk(0,1,0,32'h0 ,0, 8'h00, 24'h000200, 32'h0);
    tbl[10] = mk(0,1,1,32'h1 ,0, 8'h40, 24'h000200, 32'h1);
    tbl[11] = mk(0,1,1,32'h2 ,0, 8'h40, 24'h000200, 32'h2);
    tbl[12] = mk(0,1,1,32'h3 ,0, 8'h40, 24'h000200, 32'h3);
    tbl[13] = mk(0,1,1,32'h4 ,0, 8'h40, 24'h000200, 32'h4);
    tbl[14] = mk(0,1,1,32'h5 ,0, 8'h00, 24'h000200, 32'h0);
    tbl[15] = mk(0,1,0,32'h0 ,1, 8'h10, 24'h000200, 32'h0);
    tbl[16] = mk(0,0,0,32'h0 ,0, 8'h00, 24'h000200, 32'h0);
    r0_addr = 24'h000010;
    r1_addr = 24'h000200;
    for (int i = 0; i < 17; i++) begin
      r0_req = tbl[i].r0q; r1_req = tbl[i].r1q;
      fr_wvalid = tbl[i].wv; fr_wdata = tbl[i].wd; fr_done = tbl[i].fd;
      tick();
      chk($sformatf("tbl%0d ctl", i), 96'(ctl()), 96'(tbl[i].ectl));
      chk($sformatf("tbl%0d fr_addr", i), 96'(fr_addr), 96'(tbl[i].fa));
      if (tbl[i].ectl[7]) chk($sformatf("tbl%0d r0_rdata", i), 96'(r0_rdata), 96'(tbl[i].d));
      if (tbl[i].ectl[6]) chk($sformatf("tbl%0d r1_rdata", i), 96'(r1_rdata), 96'(tbl[i].d));
    end
    clr_in();

    // ---- simultaneous requests after reset: r0 first, r1 start at D+3 ----
    do_reset();
    r0_addr = 24'h000100; r1_addr = 24'h000200;
    r0_req = 1'b1; r1_req = 1'b1;
    tick();
    chk("tie start", 96'(ctl()), 96'(8'h02));
    chk("tie addr r0", 96'(fr_addr), 96'(24'h000100));
    tick();
    for (int w = 0; w < 4; w++) begin
      fr_wvalid = 1'b1; fr_wdata = 32'hB0 + 32'(w); fr_done = (w == 3);
      tick();
      chk($sformatf("tie word%0d ctl", w), 96'(ctl()), 96'((w == 3) ? 8'hA0 : 8'h80));
      chk($sformatf("tie word%0d data", w), 96'(r0_rdata), 96'(32'hB0 + 32'(w)));
    end
    fr_wvalid = 1'b0; fr_done = 1'b0; r0_req = 1'b0;
    tick();
    chk("tie D+2 no start", 96'(ctl()), 96'(8'h00));
    tick();
    chk("tie D+3 start", 96'(ctl()), 96'(8'h02));
    chk("tie D+3 addr r1", 96'(fr_addr), 96'(24'h000200));
    tick();
    fr_done = 1'b1;
    tick();
    chk("tie r1 done", 96'(ctl()), 96'(8'h10));
    clr_in();
    tick();

    // ---- round-robin over four bursts with immediate re-requests ----
    do_reset();
    r0_addr = 24'h000100; r1_addr = 24'h000200;
    r0_req = 1'b1; r1_req = 1'b1;
    for (int b = 0; b < 4; b++) begin
      tick();
      chk($sformatf("rr%0d start", b), 96'(fr_start), 96'(1'b1));
      chk($sformatf("rr%0d addr", b), 96'(fr_addr), 96'((b % 2 == 1) ? 24'h000200 : 24'h000100));
      tick();
      fr_wvalid = 1'b1; fr_wdata = 32'(b); fr_done = 1'b1;
      tick();
      chk($sformatf("rr%0d done", b), 96'(ctl()), 96'((b % 2 == 1) ? 8'h50 : 8'hA0));
      fr_wvalid = 1'b0; fr_done = 1'b0;
      if (b % 2 == 1) r1_req = 1'b0; else r0_req = 1'b0;
      tick();
      r0_req = 1'b1; r1_req = 1'b1;
    end
    clr_in();
    tick();

    // ---- asynchronous reset in the middle of a burst ----
    do_reset();
    r0_req = 1'b1; r0_addr = 24'h000044;
    tick();
    tick();
    fr_wvalid = 1'b1; fr_wdata = 32'h11;
    tick();
    fr_wdata = 32'h22;
    tick();
    chk("mid word2 valid", 96'(r0_rdata), 96'(32'h22));
    #2;
    HRESET = 1'b1;
    #1;
    chk("mid reset immediate", outs(), 96'h0);
    tick();
    chk("mid reset held", 96'(ctl()), 96'(8'h00));
    HRESET = 1'b0; r0_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fr_wvalid = 1'b1; fr_wdata = 32'h33 + 32'(i); fr_done = i[0];
      tick();
      chk($sformatf("post reset stray%0d", i), 96'(ctl()), 96'(8'h00));
    end
    fr_wvalid = 1'b0; fr_done = 1'b0;
    r0_addr = 24'h000500; r1_addr = 24'h000600; r0_req = 1'b1; r1_req = 1'b1;
    tick();
    chk("post reset tie start", 96'(fr_start), 96'(1'b1));
    chk("post reset tie addr", 96'(fr_addr), 96'(24'h000500));
    r1_req = 1'b0;
    tick();
    fr_done = 1'b1;
    tick();
    chk("post reset r0 done", 96'(ctl()), 96'(8'h20));
    clr_in();
    tick();

    // ---- stall behaviour ----
    do_reset();
`ifdef FILL_ARB_TIMEOUT_EN
    r0_req = 1'b1; r0_addr = 24'h000300; r1_addr = 24'h000700;
    tick();
    chk("to S start", 96'(ctl()), 96'(8'h02));
    acc = 8'h00;
    for (int j = 1; j <= 8; j++) begin
      tick();
      acc = acc | ctl();
    end
    chk("to S+1..S+8 quiet", 96'(acc), 96'(8'h00));
    r1_req = 1'b1;
    tick();
    chk("to S+9 abort", 96'(ctl()), 96'(8'h29));
    r0_req = 1'b0;
    tick();
    chk("to S+10 idle", 96'(ctl()), 96'(8'h00));
    tick();
    chk("to S+11 r1 start", 96'(ctl()), 96'(8'h02));
    chk("to S+11 r1 addr", 96'(fr_addr), 96'(24'h000700));
    r1_req = 1'b0;
    tick();
    fr_done = 1'b1;
    tick();
    chk("to r1 normal done", 96'(ctl()), 96'(8'h10));
    clr_in();
    tick();
    // fr_done on the expiry cycle completes normally
    r0_req = 1'b1;
    tick();
    for (int j = 1; j <= 7; j++) tick();
    fr_done = 1'b1;
    tick();
    chk("to precedence", 96'(ctl()), 96'(8'h20));
    clr_in();
    tick();
`else
    r0_req = 1'b1; r0_addr = 24'h000300; r1_addr = 24'h000700;
    tick();
    chk("hold S start", 96'(ctl()), 96'(8'h02));
    r1_req = 1'b1;
    acc = 8'h00;
    for (int j = 1; j <= 100; j++) begin
      tick();
      acc = acc | ctl();
    end
    chk("hold S+1..S+100 quiet", 96'(acc), 96'(8'h00));
    chk("hold S+100 addr", 96'(fr_addr), 96'(24'h000300));
    fr_done = 1'b1;
    tick();
    chk("hold release done", 96'(ctl()), 96'(8'h20));
    clr_in();
    tick();
`endif

    // ---- randomized bursts against the transaction-level model ----
    do_reset();
    pend[0] = 1'b0; pend[1] = 1'b0; mlast = 1'b1;
    for (int it = 0; it < 40; it++) begin
      int n;
      bit coinc, ended;
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1) begin
          pend[r] = 1'b1; maddr[r] = 24'($urandom);
        end
      end
      if (!pend[0] && !pend[1]) begin
        n = int'($urandom_range(0, 1));
        pend[n] = 1'b1; maddr[n] = 24'($urandom);
      end
      r0_req = pend[0]; r1_req = pend[1];
      r0_addr = maddr[0]; r1_addr = maddr[1];
      mown = (pend[0] && pend[1]) ? ~mlast : pend[1];
      mgaddr = maddr[mown];
      tick();
      chk("rnd grant start", 96'(ctl()), 96'(8'h02));
      chk("rnd grant addr", 96'(fr_addr), 96'(mgaddr));
      mlast = mown;
      if (mown) r1_addr = 24'($urandom); else r0_addr = 24'($urandom);
      tick();
      chk("rnd xfer entry", 96'(ctl()), 96'(8'h00));
      mcnt = 0;
      n = int'($urandom_range(0, 6));
      coinc = ($urandom_range(0, 1) == 1);
      ended = 1'b0;
      for (int k = 0; k < n; k++) begin
        int gap;
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) xcyc(1'b0, 32'h0, 1'b0);
        if (k == n - 1 && coinc) begin
          xcyc(1'b1, $urandom, 1'b1);
          ended = 1'b1;
        end else begin
          xcyc(1'b1, $urandom, 1'b0);
        end
      end
      if (!ended) xcyc(1'b0, 32'h0, 1'b1);
      fr_wvalid = 1'b0; fr_done = 1'b0;
      pend[mown] = 1'b0;
      r0_req = pend[0]; r1_req = pend[1];
      tick();
      chk("rnd back to idle", 96'(ctl()), 96'(8'h00));
    end
    clr_in();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
